// File: rtl/cluster_dma_completion_router.sv
// Per-stream issuer-tracking FIFOs, next/done ID counters and per-initiator completion routing.
// Define CLUSTER_DMA_BROADCAST_EVT_EN to pulse every event/IRQ bit on each retire (legacy behaviour).
module cluster_dma_completion_router #(
    parameter int unsigned NumInitiators = 9,
    parameter int unsigned NumStreams    = 1,
    parameter int unsigned TrackDepth    = 8,
    parameter int unsigned IdWidth       = 28,
    localparam int unsigned IdxW = (NumInitiators > 1) ? $clog2(NumInitiators) : 1,
    localparam int unsigned CntW = $clog2(TrackDepth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumStreams-1:0]              issue_i,
    input  logic [NumStreams-1:0][IdxW-1:0]    issuer_idx_i,
    input  logic [NumStreams-1:0]              retire_i,
    output logic [NumStreams-1:0]              stall_o,
    output logic [NumStreams-1:0][IdWidth-1:0] next_id_o,
    output logic [NumStreams-1:0][IdWidth-1:0] done_id_o,
    output logic [NumStreams-1:0][CntW-1:0]    outstanding_o,
    output logic [NumInitiators-1:0]           event_o,
    output logic [NumInitiators-1:0]           irq_o,
    output logic                               busy_o,
    output logic                               error_o
);
    localparam int unsigned PtrW = $clog2(TrackDepth);

    logic [NumStreams-1:0]           push, pop, proto_err, nonempty;
    logic [NumStreams-1:0][IdxW-1:0] head;
    logic [NumInitiators-1:0]        evt_d, evt_q;
    logic                            error_d, error_q;

    for (genvar s = 0; s < NumStreams; s++) begin : g_stream
        logic [IdxW-1:0]    mem_q [TrackDepth];
        logic [PtrW-1:0]    wr_q, wr_d, rd_q, rd_d;
        logic [CntW-1:0]    cnt_q, cnt_d;
        logic [IdWidth-1:0] next_q, next_d, done_q, done_d;
        logic               full, empty, bad_idx;

        // Full/empty come from registered state only, so a same-cycle pop never frees a slot
        // and a same-cycle push never bypasses into a pop.
        assign full    = (cnt_q == CntW'(TrackDepth));
        assign empty   = (cnt_q == '0);
        assign bad_idx = (32'(issuer_idx_i[s]) >= NumInitiators);

        assign push[s]      = issue_i[s] & ~full;
        assign pop[s]       = retire_i[s] & ~empty;
        assign proto_err[s] = (issue_i[s] & (full | bad_idx)) | (retire_i[s] & empty);
        assign head[s]      = mem_q[rd_q];
        assign nonempty[s]  = ~empty;

        always_comb begin
            wr_d   = push[s] ? wr_q + PtrW'(1) : wr_q;
            rd_d   = pop[s] ? rd_q + PtrW'(1) : rd_q;
            next_d = push[s] ? next_q + IdWidth'(1) : next_q;
            done_d = pop[s] ? done_q + IdWidth'(1) : done_q;
            cnt_d  = cnt_q;
            if (push[s] && !pop[s]) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!push[s] && pop[s]) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_q   <= '0;
                rd_q   <= '0;
                cnt_q  <= '0;
                next_q <= '0;
                done_q <= '0;
            end else begin
                wr_q   <= wr_d;
                rd_q   <= rd_d;
                cnt_q  <= cnt_d;
                next_q <= next_d;
                done_q <= done_d;
            end
        end

        // Issuer storage is plain data: only written on an accepted push, never reset.
        always_ff @(posedge clk_i) begin
            if (push[s]) begin
                mem_q[wr_q] <= issuer_idx_i[s];
            end
        end

        assign stall_o[s]       = full;
        assign next_id_o[s]     = next_q;
        assign done_id_o[s]     = done_q;
        assign outstanding_o[s] = cnt_q;
    end

    always_comb begin
        evt_d = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            if (pop[s]) begin
`ifdef CLUSTER_DMA_BROADCAST_EVT_EN
                evt_d = '1;
`else
                for (int unsigned k = 0; k < NumInitiators; k++) begin
                    if (head[s] == IdxW'(k)) begin
                        evt_d[k] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign error_d = error_q | (|proto_err);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            evt_q   <= evt_d;
            error_q <= error_d;
        end
    end

    assign event_o = evt_q;
    assign irq_o   = evt_q;
    assign busy_o  = |nonempty;
    assign error_o = error_q;

endmodule

// File: tb/tb_cluster_dma_completion_router.sv
// Testbench for cluster_dma_completion_router: directed and random steps checked against a queue model.
module tb_cluster_dma_completion_router;
    localparam int NI   = 9;
    localparam int NS   = 2;
    localparam int TD   = 8;
    localparam int IW   = 4;
    localparam int IDXW = 4;
    localparam int CNTW = 4;
`ifdef CLUSTER_DMA_BROADCAST_EVT_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic [NS-1:0]            issue_i = '0;
    logic [NS-1:0][IDXW-1:0]  issuer_idx_i = '0;
    logic [NS-1:0]            retire_i = '0;
    logic [NS-1:0]            stall_o;
    logic [NS-1:0][IW-1:0]    next_id_o;
    logic [NS-1:0][IW-1:0]    done_id_o;
    logic [NS-1:0][CNTW-1:0]  outstanding_o;
    logic [NI-1:0]            event_o;
    logic [NI-1:0]            irq_o;
    logic                     busy_o;
    logic                     error_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one queue of issuer indices per stream plus plain counters.
    int            mq [NS][$];
    int            m_next [NS];
    int            m_done [NS];
    bit            m_err;
    logic [NI-1:0] m_evt;

    cluster_dma_completion_router #(
        .NumInitiators(NI),
        .NumStreams   (NS),
        .TrackDepth   (TD),
        .IdWidth      (IW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_i      (issue_i),
        .issuer_idx_i (issuer_idx_i),
        .retire_i     (retire_i),
        .stall_o      (stall_o),
        .next_id_o    (next_id_o),
        .done_id_o    (done_id_o),
        .outstanding_o(outstanding_o),
        .event_o      (event_o),
        .irq_o        (irq_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mq[s].delete();
            m_next[s] = 0;
            m_done[s] = 0;
        end
        m_err = 1'b0;
        m_evt = '0;
    endtask

    task automatic compare_all();
        bit any_busy;
        any_busy = 1'b0;
        for (int s = 0; s < NS; s++) begin
            check($sformatf("next_id[%0d]", s), 32'(next_id_o[s]), 32'(m_next[s] % (1 << IW)));
            check($sformatf("done_id[%0d]", s), 32'(done_id_o[s]), 32'(m_done[s] % (1 << IW)));
            check($sformatf("outstanding[%0d]", s), 32'(outstanding_o[s]), 32'(mq[s].size()));
            if (mq[s].size() != 0) any_busy = 1'b1;
        end
        check("event", 32'(event_o), 32'(m_evt));
        check("irq", 32'(irq_o), 32'(m_evt));
        check("busy", 32'(busy_o), 32'(any_busy));
        check("error", 32'(error_o), 32'(m_err));
    endtask

    // One clock: drive at negedge, predict from pre-edge model state, compare after the edge.
    task automatic step(input logic [NS-1:0] iss, input int i0, input int i1, input logic [NS-1:0] ret);
        int idx [NS];
        int h;
        bit full_pre;
        @(negedge clk_i);
        idx[0] = i0;
        idx[1] = i1;
        issue_i  = iss;
        retire_i = ret;
        for (int s = 0; s < NS; s++) issuer_idx_i[s] = IDXW'(idx[s]);
        #1;
        m_evt = '0;
        for (int s = 0; s < NS; s++) begin
            full_pre = (mq[s].size() == TD);
            check($sformatf("stall[%0d]", s), 32'(stall_o[s]), 32'(full_pre));
            if (ret[s]) begin
                if (mq[s].size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h = mq[s].pop_front();
                    m_done[s]++;
                    if (BCAST) m_evt = '1;
                    else if (h < NI) m_evt[h] = 1'b1;
                end
            end
            if (iss[s]) begin
                if (idx[s] >= NI) m_err = 1'b1;
                if (full_pre) begin
                    m_err = 1'b1;
                end else begin
                    mq[s].push_back(idx[s]);
                    m_next[s]++;
                end
            end
        end
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_ni   = 1'b0;
        issue_i  = '0;
        retire_i = '0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [NI-1:0] exp_one;
        model_clear();

        // Reset and idle
        do_reset();
        check("stall_reset", 32'(stall_o), 32'(0));
        step(2'b00, 0, 0, 2'b00);
        step(2'b00, 0, 0, 2'b00);

        // Single transfer for initiator 3, retired four cycles later
        step(2'b01, 3, 0, 2'b00);
        check("next_id_after_issue", 32'(next_id_o[0]), 32'(1));
        step(2'b00, 0, 0, 2'b00);
        step(2'b00, 0, 0, 2'b00);
        step(2'b00, 0, 0, 2'b00);
        step(2'b00, 0, 0, 2'b01);
        exp_one = BCAST ? '1 : 9'b000001000;
        check("event_idx3", 32'(event_o), 32'(exp_one));
        check("irq_idx3", 32'(irq_o), 32'(exp_one));
        step(2'b00, 0, 0, 2'b00);
        check("busy_idle", 32'(busy_o), 32'(0));

        // In-order routing 0, 2, 0
        step(2'b01, 0, 0, 2'b00);
        step(2'b01, 2, 0, 2'b00);
        step(2'b01, 0, 0, 2'b00);
        step(2'b00, 0, 0, 2'b01);
        step(2'b00, 0, 0, 2'b01);
        step(2'b00, 0, 0, 2'b01);
        step(2'b00, 0, 0, 2'b00);

        // Two streams retiring for the same initiator in one cycle
        step(2'b11, 5, 5, 2'b00);
        step(2'b00, 0, 0, 2'b11);
        check("merged_event5", 32'(event_o), 32'(BCAST ? {NI{1'b1}} : 9'b000100000));
        step(2'b00, 0, 0, 2'b00);
        check("no_error_yet", 32'(error_o), 32'(0));

        // Fill stream 0, overflow, issue+retire while full, drain, retire while empty
        do_reset();
        for (int k = 0; k < TD; k++) step(2'b01, k % NI, 0, 2'b00);
        check("stall_full", 32'(stall_o[0]), 32'(1));
        check("outstanding_full", 32'(outstanding_o[0]), 32'(TD));
        step(2'b01, 4, 0, 2'b00);
        check("next_id_held", 32'(next_id_o[0]), 32'(8));
        check("error_overflow", 32'(error_o), 32'(1));
        step(2'b01, 1, 0, 2'b01);
        for (int k = 0; k < TD - 1; k++) step(2'b00, 0, 0, 2'b01);
        step(2'b01, 6, 0, 2'b01);
        step(2'b00, 0, 0, 2'b01);
        step(2'b00, 0, 0, 2'b01);
        step(2'b00, 0, 0, 2'b00);

        // Out-of-range issuer index on stream 1
        do_reset();
        step(2'b10, 0, 12, 2'b00);
        step(2'b00, 0, 0, 2'b10);
        step(2'b00, 0, 0, 2'b00);

        // ID wrap with 17 issue/retire pairs
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(2'b01, k % NI, 0, 2'b00);
            step(2'b00, 0, 0, 2'b01);
        end
        check("next_id_wrap", 32'(next_id_o[0]), 32'(1));
        check("done_id_wrap", 32'(done_id_o[0]), 32'(1));

        // Reset while transfers and a completion are pending
        step(2'b11, 1, 2, 2'b00);
        step(2'b11, 7, 8, 2'b00);
        step(2'b00, 0, 0, 2'b01);
        do_reset();
        step(2'b00, 0, 0, 2'b00);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [NS-1:0] iss, ret;
            for (int s = 0; s < NS; s++) begin
                iss[s] = ($urandom_range(0, 99) < 55);
                ret[s] = ($urandom_range(0, 99) < 45);
            end
            step(iss, $urandom_range(0, 9), $urandom_range(0, 9), ret);
            if (n == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cluster_dma_completion_router.md
# cluster_dma_completion_router

Per-stream transfer-ID and completion tracker for the multi-stream cluster DMA frontend. It sits between the round-robin distributor/backends and the per-initiator register sets. It records which initiator (core or peripheral port) issued each 1D transfer on each backend stream. On retirement it raises the termination event and IRQ only to that initiator, not to all of them. It also generates the next/done transfer IDs per stream, with parametrised ID width and tracking depth.

## Interface
- NumInitiators, default 9: number of register sets (cores + 1 peripheral port).
- NumStreams, default 1: number of backend streams.
- TrackDepth, default 8: outstanding transfers tracked per stream (power of two, ≥2).
- IdWidth, default 28: width of next/done ID counters.
- IdxW (derived) = max(1, $clog2(NumInitiators)).
- CntW (derived) = $clog2(TrackDepth+1).
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_i  in  [NumStreams]  transfer accepted by backend stream s (valid&ready).
- issuer_idx_i  in  [NumStreams][IdxW]  initiator index of the transfer being issued on s.
- retire_i  in  [NumStreams]  backend s completed its oldest transfer.
- stall_o  out  [NumStreams]  tracking FIFO of s full; frontend must mask valid to s.
- next_id_o  out  [NumStreams][IdWidth]  count of issued transfers on s, modulo 2^IdWidth.
- done_id_o  out  [NumStreams][IdWidth]  count of retired transfers on s, modulo 2^IdWidth.
- outstanding_o  out  [NumStreams][CntW]  FIFO fill level of s.
- event_o  out  [NumInitiators]  one-cycle termination event per initiator.
- irq_o  out  [NumInitiators]  one-cycle termination IRQ per initiator (same timing as event_o).
- busy_o  out  1  any stream has outstanding > 0.
- error_o  out  1  sticky protocol error.

## Operation
- Each stream s has a TrackDepth-entry FIFO of IdxW-bit issuer indices.
  - issue_i[s] pushes issuer_idx_i[s].
  - retire_i[s] pops the head; the popped index is the completing initiator.
- The ID counters increment by 1 on issue_i[s] (next) and on accepted retire_i[s] (done). They wrap from 2^IdWidth−1 to 0 with no flag.
- Retire routing:
  - event_o[k] and irq_o[k] assert for one cycle if any stream popped an entry equal to k in the previous cycle.
  - Several streams retiring for the same k in the same cycle produce one pulse, not a counted sum.
- Simultaneous issue and retire on the same stream in the same cycle: both act. The fill level is unchanged, and both ID counters increment.
- Issue when full (stall_o[s]=1): the push is dropped, next_id is not incremented, and error_o is set. A pop in the same cycle does not make room. stall_o is computed from the pre-pop fill level only.
- Retire when empty: ignored, done_id is not incremented, no event, error_o is set. A same-cycle issue does not bypass into the pop.
- issuer_idx_i ≥ NumInitiators: the value is stored, and on retire no event bit is raised. error_o is set at issue time.
- error_o clears only on reset.

## Timing
- Reset values:
  - next_id_o, done_id_o, outstanding_o = 0.
  - event_o, irq_o = 0; busy_o = 0; error_o = 0.
  - stall_o = 0 (FIFOs empty).
- next_id_o, done_id_o, outstanding_o and busy_o update in the cycle after the triggering edge.
- event_o/irq_o are registered and pulse exactly one cycle, starting one cycle after the retire_i edge.
- stall_o is combinational from FIFO state only, with no input-to-output path.
- Reset asserted mid-operation clears all FIFOs and counters immediately. Pending completions are lost and no events are generated.

## Configuration
- CLUSTER_DMA_BROADCAST_EVT_EN defined:
  - every accepted retire pulses all event_o/irq_o bits (legacy broadcast behaviour);
  - FIFOs, IDs and error checking are unchanged.
- Undefined: per-initiator routing as specified above.

## Test plan
- Reset, then idle: all outputs 0.
- NumStreams=1, issue idx 3, retire 4 cycles later:
  - next_id=1 one cycle after issue;
  - event_o=irq_o=9'b000001000 for exactly one cycle, starting one cycle after retire;
  - done_id=1; busy_o returns to 0.
- Issue idx 0,2,0 back-to-back on stream 0, then three retires: events go to 0, then 2, then 0, in order.
- NumStreams=2: both streams retire for idx 5 in the same cycle → a single pulse on bit 5; both done_id increment.
- TrackDepth=8: 8 issues → stall_o=1 and outstanding=8. A 9th issue → dropped, error_o=1, next_id stays 8. Retire with empty FIFO → no event, error_o stays 1.
- IdWidth=4: 17 issue/retire pairs → next_id_o=done_id_o=1 (wrap). Repeat with CLUSTER_DMA_BROADCAST_EVT_EN: each retire pulses all bits.
